// File: rtl/param_dff_pipe_pkg.sv
// Shared helpers for param_dff_pipe: the clog2 used to size the toggle increment,
// the toggle popcount, and the saturating add and ceiling used by the activity counter.
package param_dff_pipe_pkg;

    // popcount takes a fixed-width operand; WIDTH*DEPTH must not exceed this.
    localparam int unsigned POP_MAX_W = 1024;

    localparam int unsigned CNT_W_DEF = 16;
    localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned bits;
        longint unsigned span;
        bits = 0;
        span = 1;
        while (span < longint'(v)) begin
            span = span << 1;
            bits++;
        end
        return bits;
    endfunction

    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

    // Ceiling for a w-bit counter, i.e. 2^w - 1.
    function automatic logic [63:0] cnt_max(input int unsigned w);
        if (w >= 64) begin
            return '1;
        end
        return (64'd1 << w) - 64'd1;
    endfunction

    // acc is never above lim, so clamping the 65-bit sum is sufficient.
    function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                            input logic [63:0] inc,
                                            input logic [63:0] lim);
        logic [64:0] sum;
        sum = {1'b0, acc} + {1'b0, inc};
        return (sum > {1'b0, lim}) ? lim : sum[63:0];
    endfunction

endpackage

// File: rtl/param_dff_pipe_act_cnt_sat.sv
// act_cnt_sat: saturating accumulator of per-edge data-bit toggles.
// R and CNT_CLR both zero the count; a clear discards that edge's increment.
module act_cnt_sat
    import param_dff_pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned INC_W = 5
) (
    input  logic             C,
    input  logic             R,
    input  logic             CNT_CLR,
    input  logic [INC_W-1:0] INC,
    output logic [CNT_W-1:0] CNT
);

    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(cnt_max(CNT_W));

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = CNT_W'(sat_add(64'(cnt_q), 64'(INC), 64'(CNT_LIM)));
    end

    always_ff @(posedge C) begin
        if (R || CNT_CLR) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign CNT = cnt_q;

endmodule

// File: rtl/param_dff_pipe.sv
// param_dff_pipe: WIDTH x DEPTH register pipeline with valid tags, stall and sync set/reset.
// The toggle-activity counter is built only when PARAM_DFF_PIPE_ACTIVITY_CNT_EN is defined.
module param_dff_pipe
    import param_dff_pipe_pkg::*;
#(
    parameter int unsigned       WIDTH   = 8,
    parameter int unsigned       DEPTH   = 3,
    parameter logic [WIDTH-1:0]  SET_VAL = '1,
    parameter int unsigned       CNT_W   = 16
) (
    input  logic             C,
    input  logic             R,
    input  logic             S,
    input  logic             EN,
    input  logic [WIDTH-1:0] D,
    input  logic             VLD_I,
    output logic [WIDTH-1:0] Q,
    output logic             VLD_O,
    input  logic             CNT_CLR,
    output logic [CNT_W-1:0] CNT
);

    localparam int unsigned NB = WIDTH * DEPTH;

    logic [NB-1:0]    data_cur;
    logic [DEPTH-1:0] vld_cur;
`ifdef PARAM_DFF_PIPE_ACTIVITY_CNT_EN
    logic [NB-1:0]    data_nxt;
`endif

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] data_q;
        logic [WIDTH-1:0] data_d;
        logic [WIDTH-1:0] data_in;
        logic             vld_q;
        logic             vld_d;
        logic             vld_in;

        if (k == 0) begin : g_head
            assign data_in = D;
            assign vld_in  = VLD_I;
        end else begin : g_body
            assign data_in = data_cur[(k-1)*WIDTH +: WIDTH];
            assign vld_in  = vld_cur[k-1];
        end

        // Valid tags ride along but never gate movement.
        always_comb begin
            data_d = data_q;
            vld_d  = vld_q;
            if (S) begin
                data_d = SET_VAL;
                vld_d  = 1'b0;
            end else if (EN) begin
                data_d = data_in;
                vld_d  = vld_in;
            end
        end

        always_ff @(posedge C) begin
            if (R) begin
                data_q <= '0;
                vld_q  <= 1'b0;
            end else begin
                data_q <= data_d;
                vld_q  <= vld_d;
            end
        end

        assign data_cur[k*WIDTH +: WIDTH] = data_q;
        assign vld_cur[k]                 = vld_q;
`ifdef PARAM_DFF_PIPE_ACTIVITY_CNT_EN
        assign data_nxt[k*WIDTH +: WIDTH] = data_d;
`endif
    end

    assign Q     = data_cur[(DEPTH-1)*WIDTH +: WIDTH];
    assign VLD_O = vld_cur[DEPTH-1];

`ifdef PARAM_DFF_PIPE_ACTIVITY_CNT_EN
    localparam int unsigned INC_W = clog2(NB + 1);

    logic [POP_MAX_W-1:0] toggle_ext;
    logic [INC_W-1:0]     inc;

    always_comb begin
        toggle_ext           = '0;
        toggle_ext[NB-1:0]   = data_nxt ^ data_cur;
    end

    assign inc = INC_W'(popcount(toggle_ext));

    act_cnt_sat #(
        .CNT_W (CNT_W),
        .INC_W (INC_W)
    ) u_act_cnt (
        .C       (C),
        .R       (R),
        .CNT_CLR (CNT_CLR),
        .INC     (inc),
        .CNT     (CNT)
    );
`else
    logic cnt_clr_unused;
    assign cnt_clr_unused = CNT_CLR;
    assign CNT            = '0;
`endif

endmodule
